// File: rtl/hp_turn_controller.sv
// Two-player turn sequencer: owns both HP registers, accepts one on-turn attack,
// enforces a post-attack lockout, and reports game over and the winner.
module hp_turn_controller #(
    parameter int MAX_HP  = 10,
    parameter int DMG     = 1,
    parameter int LOCKOUT = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       ATK_1P,
    input  logic       ATK_2P,
    output logic [3:0] HP_P1,
    output logic [3:0] HP_P2,
    output logic       TURN_1P,
    output logic       ACK,
    output logic       GAME_OVER,
    output logic [1:0] WINNER,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_LOCK = 2'b10,
        S_OVER = 2'b11
    } state_t;

    localparam int            CW       = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
    localparam logic [3:0]    HP_INIT  = 4'(MAX_HP);
    localparam logic [3:0]    DMG4     = 4'(DMG);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LOCKOUT - 1);

    state_t        r_state, w_state;
    logic [3:0]    r_hp1, w_hp1, r_hp2, w_hp2;
    logic          r_turn, w_turn, r_ack, w_ack, r_over, w_over;
    logic [1:0]    r_winner, w_winner;
    logic [CW-1:0] r_cnt, w_cnt;

    logic       w_req;
    logic [3:0] w_hp_tgt, w_hp_dmg;

    // Only the on-turn player's request is seen; damage saturates at zero.
    assign w_req    = r_turn ? ATK_1P : ATK_2P;
    assign w_hp_tgt = r_turn ? r_hp2 : r_hp1;
    assign w_hp_dmg = (w_hp_tgt <= DMG4) ? 4'd0 : w_hp_tgt - DMG4;

    always_comb begin
        w_state  = r_state;
        w_hp1    = r_hp1;
        w_hp2    = r_hp2;
        w_turn   = r_turn;
        w_ack    = 1'b0;
        w_over   = r_over;
        w_winner = r_winner;
        w_cnt    = r_cnt;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (START) begin
                    w_hp1    = HP_INIT;
                    w_hp2    = HP_INIT;
                    w_turn   = 1'b1;
                    w_winner = 2'b00;
                    w_over   = 1'b0;
                    w_state  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_req) begin
                    w_ack = 1'b1;
                    if (r_turn) w_hp2 = w_hp_dmg;
                    else        w_hp1 = w_hp_dmg;
                    if (w_hp_dmg == 4'd0) begin
                        w_state  = S_OVER;
                        w_over   = 1'b1;
                        w_winner = r_turn ? 2'b01 : 2'b10;
                    end else begin
                        w_cnt   = CNT_LOAD;
                        w_state = S_LOCK;
                    end
                end
            end
            S_LOCK: begin
                if (r_cnt == '0) begin
                    w_turn  = ~r_turn;
                    w_state = S_WAIT;
                end else begin
                    w_cnt = r_cnt - CW'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_hp1    <= HP_INIT;
            r_hp2    <= HP_INIT;
            r_turn   <= 1'b1;
            r_ack    <= 1'b0;
            r_over   <= 1'b0;
            r_winner <= 2'b00;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state;
            r_hp1    <= w_hp1;
            r_hp2    <= w_hp2;
            r_turn   <= w_turn;
            r_ack    <= w_ack;
            r_over   <= w_over;
            r_winner <= w_winner;
            r_cnt    <= w_cnt;
        end
    end

    assign HP_P1     = r_hp1;
    assign HP_P2     = r_hp2;
    assign TURN_1P   = r_turn;
    assign ACK       = r_ack;
    assign GAME_OVER = r_over;
    assign WINNER    = r_winner;
    assign STATE     = r_state;

endmodule

// File: tb/tb_hp_turn_controller.sv
// Scoreboard bench: each scenario queues (stimulus, expected outputs) pairs, then
// replays them one edge at a time against a DMG=1 and a DMG=3 instance.
module tb_hp_turn_controller;

    localparam logic [1:0] I = 2'b00, W = 2'b01, L = 2'b10, O = 2'b11;

    typedef struct packed {
        logic rst;
        logic start;
        logic a1;
        logic a2;
    } stim_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst1 = 1'b1, start1 = 1'b0, a1_1 = 1'b0, a2_1 = 1'b0;
    logic       rst3 = 1'b1, start3 = 1'b0, a1_3 = 1'b0, a2_3 = 1'b0;
    logic [3:0] hp1_1, hp2_1, hp1_3, hp2_3;
    logic       turn_1, ack_1, over_1, turn_3, ack_3, over_3;
    logic [1:0] win_1, st_1, win_3, st_3;
    logic [14:0] obs1, obs3, e;

    int total = 0;
    int bad   = 0;

    stim_t       sq[$];
    logic [14:0] eq[$];
    stim_t       s;

    hp_turn_controller #(.MAX_HP(10), .DMG(1), .LOCKOUT(4)) dut1 (
        .CLK(CLK), .RST(rst1), .START(start1), .ATK_1P(a1_1), .ATK_2P(a2_1),
        .HP_P1(hp1_1), .HP_P2(hp2_1), .TURN_1P(turn_1), .ACK(ack_1),
        .GAME_OVER(over_1), .WINNER(win_1), .STATE(st_1)
    );

    hp_turn_controller #(.MAX_HP(10), .DMG(3), .LOCKOUT(4)) dut3 (
        .CLK(CLK), .RST(rst3), .START(start3), .ATK_1P(a1_3), .ATK_2P(a2_3),
        .HP_P1(hp1_3), .HP_P2(hp2_3), .TURN_1P(turn_3), .ACK(ack_3),
        .GAME_OVER(over_3), .WINNER(win_3), .STATE(st_3)
    );

    assign obs1 = {st_1, hp1_1, hp2_1, turn_1, ack_1, over_1, win_1};
    assign obs3 = {st_3, hp1_3, hp2_3, turn_3, ack_3, over_3, win_3};

    function automatic logic [14:0] ex(input logic [1:0] st, input logic [3:0] h1,
                                       input logic [3:0] h2, input logic t,
                                       input logic a, input logic o, input logic [1:0] w);
        return {st, h1, h2, t, a, o, w};
    endfunction

    task automatic add(input stim_t st, input logic [14:0] exp_v);
        sq.push_back(st);
        eq.push_back(exp_v);
    endtask

    task automatic test_reset();
        add(4'b1111, ex(I, 10, 10, 1, 0, 0, 2'b00));
        add(4'b1000, ex(I, 10, 10, 1, 0, 0, 2'b00));
        add(4'b0011, ex(I, 10, 10, 1, 0, 0, 2'b00));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            {rst1, start1, a1_1, a2_1} = s;
            @(posedge CLK); #1;
            e = eq.pop_front(); total++;
            if (obs1 !== e) begin
                bad++; $display("FAIL reset: got %h expected %h", obs1, e);
            end
        end
    endtask

    task automatic test_start();
        add(4'b0100, ex(W, 10, 10, 1, 0, 0, 2'b00));
        add(4'b0100, ex(W, 10, 10, 1, 0, 0, 2'b00));
        add(4'b0000, ex(W, 10, 10, 1, 0, 0, 2'b00));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            {rst1, start1, a1_1, a2_1} = s;
            @(posedge CLK); #1;
            e = eq.pop_front(); total++;
            if (obs1 !== e) begin
                bad++; $display("FAIL start: got %h expected %h", obs1, e);
            end
        end
    endtask

    // Both requests high with P1 on turn; P2 keeps its request held through LOCK.
    task automatic test_both_attack();
        add(4'b0011, ex(L, 10, 9, 1, 1, 0, 2'b00));
        for (int i = 0; i < 3; i++) add(4'b0001, ex(L, 10, 9, 1, 0, 0, 2'b00));
        add(4'b0101, ex(W, 10, 9, 0, 0, 0, 2'b00));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            {rst1, start1, a1_1, a2_1} = s;
            @(posedge CLK); #1;
            e = eq.pop_front(); total++;
            if (obs1 !== e) begin
                bad++; $display("FAIL both_attack: got %h expected %h", obs1, e);
            end
        end
    endtask

    task automatic test_held();
        add(4'b0001, ex(L, 9, 9, 0, 1, 0, 2'b00));
        for (int i = 0; i < 3; i++) add(4'b0001, ex(L, 9, 9, 0, 0, 0, 2'b00));
        add(4'b0001, ex(W, 9, 9, 1, 0, 0, 2'b00));
        add(4'b0001, ex(W, 9, 9, 1, 0, 0, 2'b00));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            {rst1, start1, a1_1, a2_1} = s;
            @(posedge CLK); #1;
            e = eq.pop_front(); total++;
            if (obs1 !== e) begin
                bad++; $display("FAIL held: got %h expected %h", obs1, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        add(4'b0010, ex(L, 9, 8, 1, 1, 0, 2'b00));
        for (int i = 0; i < 3; i++) add(4'b0010, ex(L, 9, 8, 1, 0, 0, 2'b00));
        add(4'b0010, ex(W, 9, 8, 0, 0, 0, 2'b00));
        add(4'b0010, ex(W, 9, 8, 0, 0, 0, 2'b00));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            {rst1, start1, a1_1, a2_1} = s;
            @(posedge CLK); #1;
            e = eq.pop_front(); total++;
            if (obs1 !== e) begin
                bad++; $display("FAIL back_to_back: got %h expected %h", obs1, e);
            end
        end
    endtask

    // Reset lands while LOCK still has two cycles of countdown left.
    task automatic test_mid_reset();
        add(4'b0001, ex(L, 8, 8, 0, 1, 0, 2'b00));
        add(4'b0000, ex(L, 8, 8, 0, 0, 0, 2'b00));
        add(4'b1000, ex(I, 10, 10, 1, 0, 0, 2'b00));
        add(4'b0001, ex(I, 10, 10, 1, 0, 0, 2'b00));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            {rst1, start1, a1_1, a2_1} = s;
            @(posedge CLK); #1;
            e = eq.pop_front(); total++;
            if (obs1 !== e) begin
                bad++; $display("FAIL mid_reset: got %h expected %h", obs1, e);
            end
        end
    endtask

    // DMG=3: P2 HP runs 7,4,1,0 while P1 HP runs 7,4,1 on the alternating turns.
    task automatic test_over();
        logic [3:0] h2v[4];
        logic [3:0] h1v[3];
        logic [3:0] h1;
        h2v = '{4'd7, 4'd4, 4'd1, 4'd0};
        h1v = '{4'd7, 4'd4, 4'd1};
        h1  = 4'd10;
        add(4'b1000, ex(I, 10, 10, 1, 0, 0, 2'b00));
        add(4'b0100, ex(W, 10, 10, 1, 0, 0, 2'b00));
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                add(4'b0010, ex(O, h1, 4'd0, 1, 1, 1, 2'b01));
            end else begin
                add(4'b0010, ex(L, h1, h2v[k], 1, 1, 0, 2'b00));
                for (int i = 0; i < 3; i++) add(4'b0000, ex(L, h1, h2v[k], 1, 0, 0, 2'b00));
                add(4'b0000, ex(W, h1, h2v[k], 0, 0, 0, 2'b00));
                h1 = h1v[k];
                add(4'b0001, ex(L, h1, h2v[k], 0, 1, 0, 2'b00));
                for (int i = 0; i < 3; i++) add(4'b0000, ex(L, h1, h2v[k], 0, 0, 0, 2'b00));
                add(4'b0000, ex(W, h1, h2v[k], 1, 0, 0, 2'b00));
            end
        end
        add(4'b0000, ex(O, 1, 0, 1, 0, 1, 2'b01));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            {rst3, start3, a1_3, a2_3} = s;
            @(posedge CLK); #1;
            e = eq.pop_front(); total++;
            if (obs3 !== e) begin
                bad++; $display("FAIL over: got %h expected %h", obs3, e);
            end
        end
    endtask

    task automatic test_over_restart();
        add(4'b0011, ex(O, 1, 0, 1, 0, 1, 2'b01));
        add(4'b0010, ex(O, 1, 0, 1, 0, 1, 2'b01));
        add(4'b0001, ex(O, 1, 0, 1, 0, 1, 2'b01));
        add(4'b0100, ex(W, 10, 10, 1, 0, 0, 2'b00));
        add(4'b0010, ex(L, 10, 7, 1, 1, 0, 2'b00));
        while (sq.size() > 0) begin
            s = sq.pop_front();
            {rst3, start3, a1_3, a2_3} = s;
            @(posedge CLK); #1;
            e = eq.pop_front(); total++;
            if (obs3 !== e) begin
                bad++; $display("FAIL over_restart: got %h expected %h", obs3, e);
            end
        end
    endtask

    initial begin
        @(posedge CLK); #1;
        test_reset();
        test_start();
        test_both_attack();
        test_held();
        test_back_to_back();
        test_mid_reset();
        test_over();
        test_over_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
